// File: rtl/data_memory_sized_if.sv
// Request/response bundle between the datapath and the data memory.
// master drives requests; slave (the memory) returns load data and status flags.
interface data_memory_sized_if;
  logic [31:0] address;
  logic [31:0] write_dat;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] read_dat;
  logic        read_vld;
  logic        busy;
  logic        misaligned;
  logic        out_of_range;

  modport master (
    output address, write_dat, mem_read, mem_write, size, unsigned_ld,
    input  read_dat, read_vld, busy, misaligned, out_of_range
  );

  modport slave (
    input  address, write_dat, mem_read, mem_write, size, unsigned_ld,
    output read_dat, read_vld, busy, misaligned, out_of_range
  );
endinterface

// File: rtl/data_memory_sized.sv
// Byte-addressable data memory with byte/half/word access, a registered load port (latency 1) and a clear sweep after reset.
// No backpressure: one request per cycle in RUN; requests arriving while busy is high are dropped.
module data_memory_sized #(
  parameter int unsigned DEPTH          = 1024,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  data_memory_sized_if.slave bus
);

  localparam int unsigned    AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]  LAST_PTR = AW'(DEPTH - 4);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    mem_q [DEPTH];

  logic [31:0]   rdata_q, rdata_d;
  logic          rvld_q, rvld_d;
  logic          mis_q, mis_d;
  logic          oor_q, oor_d;

  logic [AW-1:0] a;
  logic          req;
  logic          bad_align;
  logic          bad_range;
  logic          legal;
  logic [31:0]   raw;
  logic [31:0]   ext;
  logic [3:0]    wr_be;
  logic [AW-1:0] wr_base;
  logic [31:0]   wr_word;

  assign a         = bus.address[AW-1:0];
  assign bad_range = bus.address >= 32'(DEPTH);
  assign req       = (state_q == ST_RUN) && (bus.mem_read || bus.mem_write);
  assign legal     = req && !bad_align && !bad_range;

  always_comb begin
    bad_align = 1'b0;
    unique case (bus.size)
      2'b00:   bad_align = 1'b0;
      2'b01:   bad_align = a[0];
      2'b10:   bad_align = |a[1:0];
      default: bad_align = 1'b1;
    endcase
  end

  // Lanes above the access width may wrap; the extension mux never selects them.
  always_comb begin
    raw = '0;
    for (int k = 0; k < 4; k++) begin
      raw[8*k +: 8] = mem_q[a + AW'(k)];
    end
  end

  always_comb begin
    ext = raw;
    unique case (bus.size)
      2'b00:   ext = bus.unsigned_ld ? {24'h0, raw[7:0]}   : {{24{raw[7]}}, raw[7:0]};
      2'b01:   ext = bus.unsigned_ld ? {16'h0, raw[15:0]}  : {{16{raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_be   = 4'h0;
    wr_base = a;
    wr_word = bus.write_dat;
    rdata_d = '0;
    rvld_d  = 1'b0;
    mis_d   = 1'b0;
    oor_d   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        wr_be   = 4'hF;
        wr_base = ptr_q;
        wr_word = '0;
        ptr_d   = ptr_q + AW'(4);
        if (ptr_q == LAST_PTR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mis_d  = req && bad_align;
        oor_d  = req && !bad_align && bad_range;
        rvld_d = legal && bus.mem_read;
        if (rvld_d) begin
          rdata_d = ext;
        end
        if (legal && bus.mem_write) begin
          unique case (bus.size)
            2'b00:   wr_be = 4'b0001;
            2'b01:   wr_be = 4'b0011;
            default: wr_be = 4'b1111;
          endcase
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      ptr_q   <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      mis_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      mis_q   <= mis_d;
      oor_q   <= oor_d;
    end
  end

  // Storage carries no reset; it is qualified so nothing commits while reset is held.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (rst_ni && wr_be[k]) begin
        mem_q[wr_base + AW'(k)] <= wr_word[8*k +: 8];
      end
    end
  end

  assign bus.read_dat     = rdata_q;
  assign bus.read_vld     = rvld_q;
  assign bus.busy         = (state_q == ST_CLEAR);
  assign bus.misaligned   = mis_q;
  assign bus.out_of_range = oor_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Randomized and directed bench for data_memory_sized against a byte-array reference model.
module tb_data_memory_sized;

  localparam int DEPTH = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  data_memory_sized_if bus ();

  data_memory_sized #(
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  logic [7:0] ref_mem [DEPTH];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdat);
    bus.mem_read    = rd;
    bus.mem_write   = wr;
    bus.size        = sz;
    bus.unsigned_ld = uns;
    bus.address     = addr;
    bus.write_dat   = wdat;
  endtask

  // One request in RUN; expectations come from byte-level rules, checked in the following cycle.
  task automatic do_req(input string t, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdat,
                        output logic [31:0] got);
    int     nb;
    logic   bad_a;
    logic   bad_r;
    logic   ok;
    logic   any;
    logic [31:0] exp_d;
    longint v;
    drive(rd, wr, sz, uns, addr, wdat);
    nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    if (nb == 0) bad_a = 1'b1;
    else         bad_a = (addr % nb) != 0;
    bad_r = !bad_a && (addr >= DEPTH);
    any   = rd || wr;
    ok    = any && !bad_a && !bad_r;
    exp_d = 32'h0;
    if (ok && rd) begin
      v = 0;
      for (int i = 0; i < nb; i++) v += longint'(ref_mem[addr + i]) << (8 * i);
      if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
      exp_d = v[31:0];
    end
    @(posedge clk);
    #1;
    chk({t, "_rvld"}, 32'(bus.read_vld), 32'(ok && rd));
    chk({t, "_rdat"}, bus.read_dat, exp_d);
    chk({t, "_mis"},  32'(bus.misaligned), 32'(any && bad_a));
    chk({t, "_oor"},  32'(bus.out_of_range), 32'(any && bad_r));
    chk({t, "_busy"}, 32'(bus.busy), 32'd0);
    if (ok && wr) begin
      for (int i = 0; i < nb; i++) ref_mem[addr + i] = wdat[8*i +: 8];
    end
    got = bus.read_dat;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rvld", 32'(bus.read_vld), 32'd0);
    chk("rst_rdat", bus.read_dat, 32'd0);
    chk("rst_mis",  32'(bus.misaligned), 32'd0);
    chk("rst_oor",  32'(bus.out_of_range), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endtask

  // Random requests while busy must all be dropped; returns cycles spent busy.
  task automatic run_sweep(input int limit, output int n);
    n = 0;
    while (bus.busy && n < limit) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH + 7)), $urandom);
      @(posedge clk);
      #1;
      n++;
      chk("drop_rvld", 32'(bus.read_vld), 32'd0);
      chk("drop_rdat", bus.read_dat, 32'd0);
      chk("drop_mis",  32'(bus.misaligned), 32'd0);
      chk("drop_oor",  32'(bus.out_of_range), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] got;
    logic [31:0] addr;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    #2;

    apply_reset();
    run_sweep(2000, n);
    chk("sweep_len", 32'(n), 32'(DEPTH / 4));

    do_req("t1", 1'b1, 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, got);
    chk("t1_word", got, 32'h0);

    do_req("t2st", 1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, got);
    do_req("t2sx", 1'b1, 1'b0, 2'd0, 1'b0, 32'h12, 32'h0, got);
    chk("t2_sx", got, 32'hFFFFFFFF);
    do_req("t2zx", 1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, got);
    chk("t2_zx", got, 32'h00000080);

    do_req("t3st", 1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h1234BEEF, got);
    do_req("t3w",  1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, got);
    chk("t3_word", got, 32'hBEEF0000);
    do_req("t3h",  1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, got);
    chk("t3_half", got, 32'hFFFFBEEF);

    do_req("t4st", 1'b0, 1'b1, 2'd2, 1'b0, 32'h06, 32'hDEADBEEF, got);
    chk("t4_mis", 32'(bus.misaligned), 32'd1);
    do_req("t4ld", 1'b1, 1'b0, 2'd2, 1'b0, 32'h04, 32'h0, got);
    chk("t4_nochg", got, 32'h0);
    do_req("t4or", 1'b1, 1'b0, 2'd0, 1'b0, 32'h400, 32'h0, got);
    chk("t4_oor", 32'(bus.out_of_range), 32'd1);
    chk("t4_rvld", 32'(bus.read_vld), 32'd0);

    do_req("t5a", 1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h11111111, got);
    do_req("t5b", 1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h22222222, got);
    chk("t5_rbw", got, 32'h11111111);
    do_req("t5c", 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, got);
    chk("t5_new", got, 32'h22222222);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0:       addr = 32'(DEPTH - 8 + $urandom_range(0, 15));
        1:       addr = $urandom;
        default: addr = 32'($urandom_range(0, 95));
      endcase
      do_req("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), addr, $urandom, got);
    end

    do_req("t6st", 1'b0, 1'b1, 2'd0, 1'b0, 32'h200, 32'h000000AA, got);
    do_req("t6ld", 1'b1, 1'b0, 2'd0, 1'b1, 32'h200, 32'h0, got);
    chk("t6_pre", got, 32'h000000AA);
    apply_reset();
    run_sweep(64, n);
    chk("t6_part", 32'(n), 32'd64);
    chk("t6_midbusy", 32'(bus.busy), 32'd1);
    apply_reset();
    run_sweep(2000, n);
    chk("t6_sweep_len", 32'(n), 32'(DEPTH / 4));
    do_req("t6b", 1'b1, 1'b0, 2'd0, 1'b1, 32'h200, 32'h0, got);
    chk("t6_clr", got, 32'h0);
    do_req("t6w", 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, got);
    chk("t6_clrw", got, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
